// File: rtl/pwm_hbridge_dt.sv
// pwm_hbridge_dt: signed-duty H-bridge PWM with period-aligned duty updates, reversal dead time and brake
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   wrt_duty     one-cycle strobe capturing duty into the pending buffer
//   duty         signed duty; positive drives CH_A, negative drives CH_B
//   brake        level; holds both gate drives low while high
//   CH_A, CH_B   registered forward/reverse gate drives
//   period_start registered pulse during the cycle where the counter is 0
module pwm_hbridge_dt #(
    parameter int CNT_W    = 13,
    parameter int DEAD_CYC = 32,
    parameter int DT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrt_duty,
    input  logic [CNT_W:0]   duty,
    input  logic             brake,
    output logic             CH_A,
    output logic             CH_B,
    output logic             period_start
);
    typedef enum logic [1:0] {IDLE, DRV_A, DRV_B, DEAD} state_t;
    typedef enum logic [1:0] {NONE, DIR_A, DIR_B} dir_t;
    localparam logic [CNT_W-1:0] MAX     = '1;
    localparam logic [CNT_W:0]   ONE     = (CNT_W+1)'(1);
    localparam logic [DT_W-1:0]  DT_LOAD = DT_W'(DEAD_CYC - 1);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   pend, active, mag;
    logic             pend_vld, wrap, pos, neg, drive_a, drive_b;
    logic [DT_W-1:0]  dt_cnt, dt_cnt_n;
    state_t           state, state_n;
    dir_t             last_dir, last_dir_n, tgt, tgt_n;
    assign wrap    = cnt == MAX;
    assign neg     = active[CNT_W];
    assign pos     = !neg && (active != '0);
    // One extra bit keeps the most negative duty at a full-period magnitude.
    assign mag     = neg ? ~active + ONE : active;
    assign drive_a = (state == DRV_A) && pos && !brake;
    assign drive_b = (state == DRV_B) && neg && !brake;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            pend         <= '0;
            pend_vld     <= 1'b0;
            active       <= '0;
            period_start <= 1'b0;
            CH_A         <= 1'b0;
            CH_B         <= 1'b0;
        end else begin
            cnt          <= cnt + CNT_W'(1);
            period_start <= wrap;
            pend_vld     <= wrap ? 1'b0 : (wrt_duty || pend_vld);
            if (wrt_duty)
                pend <= duty;
            // A write landing on the boundary cycle bypasses the buffer.
            if (wrap)
                active <= wrt_duty ? duty : (pend_vld ? pend : active);
            CH_A <= drive_a && ({1'b0, cnt} < mag);
            CH_B <= drive_b && ({1'b0, cnt} < mag);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_dir <= NONE;
            tgt      <= NONE;
            dt_cnt   <= '0;
        end else begin
            state    <= state_n;
            last_dir <= last_dir_n;
            tgt      <= tgt_n;
            dt_cnt   <= dt_cnt_n;
        end
    end
    always_comb begin
        state_n    = state;
        last_dir_n = last_dir;
        tgt_n      = tgt;
        dt_cnt_n   = dt_cnt;
        case (state)
            IDLE:
                if (pos || neg) begin
                    // Coming back from zero still needs dead time if the last driven side was the other one.
                    if (last_dir == (pos ? DIR_B : DIR_A)) begin
                        state_n  = DEAD;
                        tgt_n    = pos ? DIR_A : DIR_B;
                        dt_cnt_n = DT_LOAD;
                    end else begin
                        state_n    = pos ? DRV_A : DRV_B;
                        last_dir_n = pos ? DIR_A : DIR_B;
                    end
                end
            DRV_A:
                if (!pos) begin
                    state_n  = neg ? DEAD : IDLE;
                    tgt_n    = neg ? DIR_B : tgt;
                    dt_cnt_n = neg ? DT_LOAD : dt_cnt;
                end
            DRV_B:
                if (!neg) begin
                    state_n  = pos ? DEAD : IDLE;
                    tgt_n    = pos ? DIR_A : tgt;
                    dt_cnt_n = pos ? DT_LOAD : dt_cnt;
                end
            DEAD:
                if (dt_cnt != '0)
                    dt_cnt_n = dt_cnt - DT_W'(1);
                else if (!pos && !neg) begin
                    state_n    = IDLE;
                    last_dir_n = NONE;
                end else if (pos == (tgt == DIR_A)) begin
                    state_n    = pos ? DRV_A : DRV_B;
                    last_dir_n = tgt;
                end else begin
                    tgt_n    = pos ? DIR_A : DIR_B;
                    dt_cnt_n = DT_LOAD;
                end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pwm_hbridge_dt.sv
// tb_pwm_hbridge_dt: per-period scoreboard check of pwm_hbridge_dt with CNT_W=6, DEAD_CYC=4
// Each period window covers counter values 1..63 then 0 (position 64); the monitor
// summarises every window and compares it against the next queued expectation.
module tb_pwm_hbridge_dt;
    localparam int CNT_W = 6, DEAD_CYC = 4, DT_W = 4, PER = 64;
    logic clk = 1'b0, rst_n = 1'b0, wrt_duty = 1'b0, brake = 1'b0;
    logic [CNT_W:0] duty = '0;
    logic CH_A, CH_B, period_start;
    pwm_hbridge_dt #(.CNT_W(CNT_W), .DEAD_CYC(DEAD_CYC), .DT_W(DT_W)) dut (
        .clk(clk), .rst_n(rst_n), .wrt_duty(wrt_duty), .duty(duty), .brake(brake),
        .CH_A(CH_A), .CH_B(CH_B), .period_start(period_start)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        int a_n; int a_f; int a_l; int b_n; int b_f; int b_l; int ps_n; int ps_p; int ov;
    } win_t;
    typedef struct {
        int   duty;
        win_t e1;
        win_t e2;
    } vec_t;
    win_t exp_q[$];
    win_t cur = '0;
    win_t e;
    int tb_cnt = 0, n_win = 0, n_chk = 0, n_fail = 0, p;
    function automatic win_t w(input int an, af, al, bn, bf, bl);
        win_t r;
        r.a_n = an; r.a_f = af; r.a_l = al;
        r.b_n = bn; r.b_f = bf; r.b_l = bl;
        r.ps_n = 1; r.ps_p = PER; r.ov = 0;
        return r;
    endfunction
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_cnt <= 0;
        else tb_cnt <= (tb_cnt + 1) % PER;
    always @(negedge clk) begin
        if (!rst_n)
            cur = '0;
        else begin
            p = (tb_cnt == 0) ? PER : tb_cnt;
            if (CH_A) begin
                if (cur.a_n == 0) cur.a_f = p;
                cur.a_l = p;
                cur.a_n++;
            end
            if (CH_B) begin
                if (cur.b_n == 0) cur.b_f = p;
                cur.b_l = p;
                cur.b_n++;
            end
            if (period_start) begin
                cur.ps_n++;
                cur.ps_p = p;
            end
            if (CH_A && CH_B) cur.ov++;
            if (tb_cnt == 0) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_chk++;
                    if (cur != e) begin
                        n_fail++;
                        $display("FAIL window %0d: got A n/first/last %0d/%0d/%0d B %0d/%0d/%0d ps %0d@%0d overlap %0d, want A %0d/%0d/%0d B %0d/%0d/%0d ps %0d@%0d overlap %0d",
                                 n_win, cur.a_n, cur.a_f, cur.a_l, cur.b_n, cur.b_f, cur.b_l, cur.ps_n, cur.ps_p, cur.ov,
                                 e.a_n, e.a_f, e.a_l, e.b_n, e.b_f, e.b_l, e.ps_n, e.ps_p, e.ov);
                    end
                end
                cur = '0;
                n_win++;
            end
        end
    end
    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic goto_cnt(input int k);
        for (int i = 0; i < 200 && tb_cnt != k; i++) tick();
        chk("goto counter position", tb_cnt, k);
    endtask
    task automatic wr(input int d);
        wrt_duty = 1'b1;
        duty = (CNT_W+1)'(d);
        tick();
        wrt_duty = 1'b0;
    endtask
    task automatic wait_win();
        int n0 = n_win;
        for (int i = 0; i < 200 && n_win == n0; i++) tick();
        chk("window completion", n_win - n0, 1);
    endtask
    task automatic expect_win(input win_t x);
        exp_q.push_back(x);
        wait_win();
    endtask
    initial begin
        vec_t v[10];
        v[0] = '{ 20, w(19, 2, 20, 0, 0, 0), w(20, 1, 20, 0, 0, 0)};
        v[1] = '{-30, w(0, 0, 0, 25, 6, 30),  w(0, 0, 0, 30, 1, 30)};
        v[2] = '{-64, w(0, 0, 0, 64, 1, 64),  w(0, 0, 0, 64, 1, 64)};
        v[3] = '{ 63, w(58, 6, 63, 0, 0, 0),  w(63, 1, 63, 0, 0, 0)};
        v[4] = '{  0, w(0, 0, 0, 0, 0, 0),    w(0, 0, 0, 0, 0, 0)};
        v[5] = '{-10, w(0, 0, 0, 5, 6, 10),   w(0, 0, 0, 10, 1, 10)};
        v[6] = '{  5, w(0, 0, 0, 0, 0, 0),    w(5, 1, 5, 0, 0, 0)};
        v[7] = '{ -1, w(0, 0, 0, 0, 0, 0),    w(0, 0, 0, 1, 1, 1)};
        v[8] = '{  0, w(0, 0, 0, 0, 0, 0),    w(0, 0, 0, 0, 0, 0)};
        v[9] = '{ 20, w(15, 6, 20, 0, 0, 0),  w(20, 1, 20, 0, 0, 0)};
        repeat (3) tick();
        chk("reset CH_A", int'(CH_A), 0);
        chk("reset CH_B", int'(CH_B), 0);
        chk("reset period_start", int'(period_start), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            goto_cnt(1);
            wr(v[i].duty);
            wait_win();
            expect_win(v[i].e1);
            expect_win(v[i].e2);
        end
        // Mid-period write does not disturb the running period.
        goto_cnt(10);
        wr(-30);
        expect_win(w(20, 1, 20, 0, 0, 0));
        expect_win(w(0, 0, 0, 25, 6, 30));
        goto_cnt(1);
        wr(20);
        expect_win(w(0, 0, 0, 30, 1, 30));
        expect_win(w(15, 6, 20, 0, 0, 0));
        // Last write in a period wins; a write on the boundary cycle applies at once.
        goto_cnt(3);
        wr(5);
        goto_cnt(8);
        wr(40);
        expect_win(w(20, 1, 20, 0, 0, 0));
        expect_win(w(40, 1, 40, 0, 0, 0));
        goto_cnt(20);
        wr(7);
        goto_cnt(63);
        wr(12);
        expect_win(w(40, 1, 40, 0, 0, 0));
        expect_win(w(12, 1, 12, 0, 0, 0));
        // Brake across a period boundary, released mid-window.
        goto_cnt(1);
        wr(20);
        expect_win(w(12, 1, 12, 0, 0, 0));
        expect_win(w(20, 1, 20, 0, 0, 0));
        exp_q.push_back(w(10, 1, 10, 0, 0, 0));
        exp_q.push_back(w(4, 17, 20, 0, 0, 0));
        goto_cnt(10);
        brake = 1'b1;
        repeat (70) tick();
        brake = 1'b0;
        wait_win();
        expect_win(w(20, 1, 20, 0, 0, 0));
        // Reset while in dead time clears the direction history.
        goto_cnt(30);
        wr(-10);
        wait_win();
        tick();
        rst_n = 1'b0;
        #1;
        chk("reset in dead CH_A", int'(CH_A), 0);
        chk("reset in dead CH_B", int'(CH_B), 0);
        chk("reset in dead period_start", int'(period_start), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        goto_cnt(5);
        wr(-10);
        wait_win();
        expect_win(w(0, 0, 0, 9, 2, 10));
        expect_win(w(0, 0, 0, 10, 1, 10));
        // Reset while a channel is high drops it without waiting for a clock.
        goto_cnt(5);
        chk("pre-reset CH_B", int'(CH_B), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset CH_B", int'(CH_B), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
